fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and id width helper for fifo_wr_arbiter
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } arb_state_e;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// rtl/fifo_wr_arbiter_rr.sv - combinational round-robin selector (module rr_arbiter)
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int cand;

    // First requester at or after ptr wins, wrapping N_REQ-1 -> 0.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-limited round-robin write arbiter into a sync FIFO
// Define FIFO_ARB_SRC_ID_EN to prepend the owner index to fifo_wr_data.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = id_w(N_REQ),
`ifdef FIFO_ARB_SRC_ID_EN
    localparam int OUT_W     = DATA_WIDTH + ID_W
`else
    localparam int OUT_W     = DATA_WIDTH
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [OUT_W-1:0]            fifo_wr_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e             state;
    logic [ID_W-1:0]        owner;
    logic [N_REQ-1:0]       owner_oh;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       beat_cnt;
    logic [ID_W-1:0]        sel_idx;
    logic [N_REQ-1:0]       sel_grant;
    logic                   sel_any;
    logic [ID_W-1:0]        next_ptr;
    logic                   owner_valid;
    logic                   last_beat;
    logic [DATA_WIDTH-1:0]  payload;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign owner_valid = req_valid[owner];
    assign payload     = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr    = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));

    // Handshake is purely combinational off registered state so a stall costs no cycle.
    assign busy       = (state == GRANT);
    assign req_ready  = (busy && !fifo_full) ? owner_oh : '0;
    assign fifo_wr_en = busy && owner_valid && !fifo_full;
    assign grant_id   = owner;

`ifdef FIFO_ARB_SRC_ID_EN
    assign fifo_wr_data = {owner, payload};
`else
    assign fifo_wr_data = payload;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            owner_oh <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state    <= GRANT;
                        owner    <= sel_idx;
                        owner_oh <= sel_grant;
                    end
                end
                GRANT: begin
                    // A dropped valid releases even while the FIFO is stalling.
                    if (!owner_valid || (fifo_wr_en && last_beat)) begin
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
